// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision constants, field slices and the FSM state set
// used by the float multiplier, adder and accumulator stages.
package float_pkg;

  localparam int unsigned E_W = 10;   // signed unbiased exponent width
  localparam int unsigned M_W = 27;   // hidden bit + 23 frac + guard/round/sticky
  localparam int unsigned S_W = 28;   // mantissa sum incl. carry-out

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;

  localparam logic [31:0] QNAN    = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam logic signed [E_W-1:0] BIAS      = 10'sd127;
  localparam logic signed [E_W-1:0] EMIN      = -10'sd126;
  localparam logic signed [E_W-1:0] EMAX      = 10'sd127;
  localparam logic signed [E_W-1:0] ALIGN_MAX = 10'sd26;

  typedef enum logic [3:0] {
    GET_X, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1, NORM, ROUND, PACK, COUNT, PUT_SUM
  } fp_state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[FRAC_MSB:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[FRAC_MSB:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return v[EXP_MSB:0] == 31'd0;
  endfunction

endpackage

// File: rtl/float_round_pack.sv
// Round-to-nearest-even and IEEE single pack, with overflow to infinity and
// denormal encoding. Purely combinational.
module float_round_pack
  import float_pkg::*;
(
  input  logic                  z_s,
  input  logic signed [E_W-1:0] z_e,
  input  logic [23:0]           z_m,
  input  logic                  g,
  input  logic                  r,
  input  logic                  s,
  output logic [31:0]           z_c
);

  logic                  round_up;
  logic [24:0]           m_inc;
  logic [23:0]           m_rnd;
  logic signed [E_W-1:0] e_rnd;

  always_comb begin
    round_up = g & (r | s | z_m[0]);
    m_inc    = {1'b0, z_m} + 25'(round_up);
    m_rnd    = m_inc[23:0];
    e_rnd    = z_e;
    // mantissa overflow from rounding renormalises by one place
    if (m_inc[24]) begin
      m_rnd = m_inc[24:1];
      e_rnd = z_e + E_W'(1);
    end
    if (e_rnd > EMAX) begin
      z_c = {z_s, 8'hFF, 23'd0};
    end else if ((e_rnd == EMIN) && !m_rnd[23]) begin
      z_c = {z_s, 8'h00, m_rnd[22:0]};
    end else begin
      z_c = {z_s, 8'(e_rnd + BIAS), m_rnd[22:0]};
    end
  end

endmodule

// File: rtl/float_accumulator.sv
// Iterative single-precision accumulator: adds N_TERMS handshaked addends into acc
// and emits one sum per group over a stb/ack output handshake.
module float_accumulator
  import float_pkg::*;
#(
  parameter int unsigned N_TERMS = 10,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_x,
  input  logic        input_x_stb,
  output logic        input_x_ack,
  output logic [31:0] output_sum,
  output logic        output_sum_stb,
  input  logic        output_sum_ack
);

  fp_state_t             state, state_nxt;
  logic [31:0]           acc, x, packed_z;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic [M_W-1:0]        a_m, b_m;
  logic signed [E_W-1:0] a_e, b_e, z_e;
  logic signed [E_W-1:0] ab_diff_c, ba_diff_c;
  logic                  a_s, b_s, z_s;
  logic [S_W-1:0]        sum;
  logic [23:0]           z_m;
  logic                  g, r, s;
  logic [31:0]           rp_z_c;
  logic                  last_term_c, special_hit_c;

  assign cnt_inc       = cnt + CNT_W'(1);
  assign last_term_c   = (cnt_inc == CNT_W'(N_TERMS));
  assign ab_diff_c     = a_e - b_e;
  assign ba_diff_c     = b_e - a_e;
  assign special_hit_c = is_nan(acc) | is_nan(x) | is_inf(acc) | is_inf(x) |
                         is_zero(acc) | is_zero(x);

  float_round_pack u_round_pack (
    .z_s (z_s),
    .z_e (z_e),
    .z_m (z_m),
    .g   (g),
    .r   (r),
    .s   (s),
    .z_c (rp_z_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET_X;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_X:   if (input_x_ack && input_x_stb) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = special_hit_c ? COUNT : ALIGN;
      ALIGN:   if (a_e == b_e) state_nxt = ADD_0;
      ADD_0:   state_nxt = ADD_1;
      ADD_1:   state_nxt = NORM;
      NORM:    if (z_m[23] || (z_e <= EMIN)) state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = COUNT;
      COUNT:   state_nxt = last_term_c ? PUT_SUM : GET_X;
      PUT_SUM: if (output_sum_stb && output_sum_ack) state_nxt = GET_X;
      default: state_nxt = GET_X;
    endcase
  end

  // Datapath and registered handshake outputs, advanced per FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= 32'd0;
      x              <= 32'd0;
      packed_z       <= 32'd0;
      cnt            <= '0;
      a_m            <= '0;
      b_m            <= '0;
      a_e            <= '0;
      b_e            <= '0;
      z_e            <= '0;
      a_s            <= 1'b0;
      b_s            <= 1'b0;
      z_s            <= 1'b0;
      sum            <= '0;
      z_m            <= '0;
      g              <= 1'b0;
      r              <= 1'b0;
      s              <= 1'b0;
      input_x_ack    <= 1'b0;
      output_sum     <= 32'd0;
      output_sum_stb <= 1'b0;
    end else begin
      case (state)
        GET_X: begin
          input_x_ack <= 1'b1;
          if (input_x_ack && input_x_stb) begin
            x           <= input_x;
            input_x_ack <= 1'b0;
          end
        end
        UNPACK: begin
          a_m <= {1'b0, acc[FRAC_MSB:0], 3'b000};
          b_m <= {1'b0, x[FRAC_MSB:0], 3'b000};
          a_e <= $signed({2'b00, acc[EXP_MSB:EXP_LSB]}) - BIAS;
          b_e <= $signed({2'b00, x[EXP_MSB:EXP_LSB]}) - BIAS;
          a_s <= acc[SIGN_BIT];
          b_s <= x[SIGN_BIT];
        end
        SPECIAL: begin
          if (is_nan(acc) || is_nan(x)) begin
            acc <= QNAN;
          end else if (is_inf(acc) && is_inf(x) && (a_s != b_s)) begin
            acc <= QNAN;
          end else if (is_inf(acc)) begin
            acc <= acc;
          end else if (is_inf(x)) begin
            acc <= x;
          end else if (is_zero(x)) begin
            // only -0 + -0 keeps the negative zero
            if (is_zero(acc)) acc <= {a_s & b_s, 31'd0};
          end else if (is_zero(acc)) begin
            acc <= x;
          end else begin
            if (acc[EXP_MSB:EXP_LSB] == 8'd0) a_e <= EMIN;
            else                              a_m[M_W-1] <= 1'b1;
            if (x[EXP_MSB:EXP_LSB] == 8'd0)   b_e <= EMIN;
            else                              b_m[M_W-1] <= 1'b1;
          end
        end
        ALIGN: begin
          if (a_e > b_e) begin
            if (ab_diff_c > ALIGN_MAX) begin
              b_m <= {{(M_W-1){1'b0}}, |b_m};
              b_e <= a_e;
            end else begin
              b_m <= {1'b0, b_m[M_W-1:2], |b_m[1:0]};
              b_e <= b_e + E_W'(1);
            end
          end else if (b_e > a_e) begin
            if (ba_diff_c > ALIGN_MAX) begin
              a_m <= {{(M_W-1){1'b0}}, |a_m};
              a_e <= b_e;
            end else begin
              a_m <= {1'b0, a_m[M_W-1:2], |a_m[1:0]};
              a_e <= a_e + E_W'(1);
            end
          end
        end
        ADD_0: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            sum <= S_W'(a_m) + S_W'(b_m);
            z_s <= a_s;
          end else if (a_m >= b_m) begin
            sum <= S_W'(a_m - b_m);
            z_s <= a_s & (a_m != b_m);
          end else begin
            sum <= S_W'(b_m - a_m);
            z_s <= b_s;
          end
        end
        ADD_1: begin
          if (sum[S_W-1]) begin
            z_m <= sum[27:4];
            g   <= sum[3];
            r   <= sum[2];
            s   <= |sum[1:0];
            z_e <= z_e + E_W'(1);
          end else begin
            z_m <= sum[26:3];
            g   <= sum[2];
            r   <= sum[1];
            s   <= sum[0];
          end
        end
        NORM: begin
          if (!z_m[23] && (z_e > EMIN)) begin
            z_m <= {z_m[22:0], g};
            g   <= r;
            r   <= 1'b0;
            z_e <= z_e - E_W'(1);
          end
        end
        ROUND:   packed_z <= rp_z_c;
        PACK:    acc <= packed_z;
        COUNT: begin
          cnt <= cnt_inc;
          if (last_term_c) output_sum <= acc;
        end
        PUT_SUM: begin
          output_sum_stb <= 1'b1;
          if (output_sum_stb && output_sum_ack) begin
            output_sum_stb <= 1'b0;
            acc            <= 32'd0;
            cnt            <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// Scoreboard bench for float_accumulator (N_TERMS=4): per-group expected sums are
// queued as terms are driven and compared when the DUT presents output_sum.
module tb_float_accumulator;

  localparam int unsigned N_GROUPS = 13;

  logic        clk;
  logic        rst;
  logic [31:0] input_x;
  logic        input_x_stb;
  logic        input_x_ack;
  logic [31:0] output_sum;
  logic        output_sum_stb;
  logic        output_sum_ack;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // four addends followed by the expected group sum
  logic [31:0] vec [N_GROUPS][5] = '{
    '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000},
    '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h80000000, 32'h00000000},
    '{32'h3F800001, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800002},
    '{32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800000},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 32'h7F800000},
    '{32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'hFFC00000},
    '{32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000002},
    '{32'h00400000, 32'h00400000, 32'h00000000, 32'h00000000, 32'h00800000},
    '{32'h3F800000, 32'hBF400000, 32'h40000000, 32'hC1200000, 32'hC0F80000},
    '{32'h3F800000, 32'h4F800000, 32'h00000000, 32'h00000000, 32'h4F800000},
    '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000},
    '{32'hBF800000, 32'h00000000, 32'h80000000, 32'h00000000, 32'hBF800000},
    '{32'h7FC00000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'hFFC00000}
  };

  float_accumulator #(.N_TERMS(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_x        (input_x),
    .input_x_stb    (input_x_stb),
    .input_x_ack    (input_x_ack),
    .output_sum     (output_sum),
    .output_sum_stb (output_sum_stb),
    .output_sum_ack (output_sum_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  task automatic send_x(input logic [31:0] v);
    int waited = 0;
    @(negedge clk);
    input_x     = v;
    input_x_stb = 1'b1;
    while (!input_x_ack && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!input_x_ack) check("x_ack_timeout", 32'(input_x_ack), 32'd1);
    @(posedge clk);
    #1;
    input_x_stb = 1'b0;
  endtask

  task automatic get_sum(input string tag, input int hold);
    logic [31:0] exp_v;
    int waited = 0;
    while (!output_sum_stb && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check({tag, "_stb"}, 32'(output_sum_stb), 32'd1);
    check(tag, output_sum, exp_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stb"}, 32'(output_sum_stb), 32'd1);
      check({tag, "_hold_sum"}, output_sum, exp_v);
      check({tag, "_hold_xack"}, 32'(input_x_ack), 32'd0);
    end
    @(negedge clk);
    output_sum_ack = 1'b1;
    @(posedge clk);
    #1;
    output_sum_ack = 1'b0;
    check({tag, "_stb_drop"}, 32'(output_sum_stb), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    input_x        = 32'd0;
    input_x_stb    = 1'b0;
    output_sum_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_xack", 32'(input_x_ack), 32'd0);
    check("rst_sum", output_sum, 32'd0);
    check("rst_stb", 32'(output_sum_stb), 32'd0);
    rst = 1'b0;

    for (int gi = 0; gi < N_GROUPS; gi++) begin
      exp_q.push_back(vec[gi][4]);
      for (int t = 0; t < 4; t++) send_x(vec[gi][t]);
      get_sum($sformatf("grp%0d", gi), (gi == 0) ? 20 : 0);
    end

    // reset mid-group: partial sum discarded, outputs clear asynchronously
    send_x(32'h3F800000);
    send_x(32'h3F800000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_xack", 32'(input_x_ack), 32'd0);
    check("midrst_sum", output_sum, 32'd0);
    check("midrst_stb", 32'(output_sum_stb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h40800000);
    for (int t = 0; t < 4; t++) send_x(32'h3F800000);
    get_sum("post_rst", 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
